// File: rtl/shift_pkg.sv
// Shared types and widths for the two-port shift arbiter and its funnel shifter.
package shift_pkg;

    localparam int unsigned SH_W  = 8;
    localparam int unsigned SH_AW = 3;
    localparam int unsigned SH_NW = 4;

    typedef struct packed {
        logic rot;
        logic lr;
        logic ar;
    } shift_op_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/shift_arbiter_if.sv
// Request/response bundle between the two issuing datapaths, the arbiter and the result consumer.
interface shift_arbiter_if;
    import shift_pkg::*;

    logic                 req0_valid;
    logic                 req0_ready;
    logic [SH_W-1:0]      req0_data;
    logic [SH_AW-1:0]     req0_amt;
    shift_op_t            req0_op;

    logic                 req1_valid;
    logic                 req1_ready;
    logic [SH_W-1:0]      req1_data;
    logic [SH_AW-1:0]     req1_amt;
    shift_op_t            req1_op;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [SH_W-1:0]      rsp_data;
    logic                 rsp_id;

    modport master (
        output req0_valid, req0_data, req0_amt, req0_op,
        output req1_valid, req1_data, req1_amt, req1_op,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req0_valid, req0_data, req0_amt, req0_op,
        input  req1_valid, req1_data, req1_amt, req1_op,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_data, rsp_id
    );

endinterface

// File: rtl/funnelShifter.sv
// 8-bit funnel shifter: logical/arithmetic shifts and rotates through one double-width shift.
module funnelShifter
    import shift_pkg::*;
(
    input  logic [SH_W-1:0]  a,
    input  logic [SH_NW-1:0] n,
    input  shift_op_t        op,
    output logic [SH_W-1:0]  y
);

    logic [SH_W-1:0]   fill;
    logic [2*SH_W-1:0] funnel;
    logic [2*SH_W-1:0] shifted;

    // Rotates feed the operand back in; arithmetic right feeds the sign; otherwise zeros.
    always_comb begin
        if (op.rot) begin
            fill = a;
        end else if (op.ar && !op.lr) begin
            fill = {SH_W{a[SH_W-1]}};
        end else begin
            fill = '0;
        end

        if (op.lr) begin
            funnel  = {a, fill};
            shifted = funnel << n;
            y       = shifted[2*SH_W-1:SH_W];
        end else begin
            funnel  = {fill, a};
            shifted = funnel >> n;
            y       = shifted[SH_W-1:0];
        end
    end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on a tie the port that was not granted last wins.
module rr_arb2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last,
    output logic grant,
    output logic grant_any
);

    always_comb begin
        grant_any = valid0 | valid1;
        if (valid0 && valid1) begin
            grant = ~last;
        end else begin
            grant = valid1;
        end
    end

endmodule

// File: rtl/shift_arbiter.sv
// Shares one funnel shifter between two requesters and registers the result into a
// single-entry output stage tagged with the issuing port.
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int unsigned W  = SH_W,
    parameter int unsigned AW = SH_AW
) (
    input  logic            clk,
    input  logic            nrst,
    shift_arbiter_if.slave  bus
);

    logic           grant;
    logic           grant_any;
    logic           slot_free;
    logic           accept;

    logic [W-1:0]   sel_data;
    logic [AW-1:0]  sel_amt;
    shift_op_t      sel_op;
    logic [W-1:0]   sh_y;

    out_state_t     state_q, state_d;
    logic           last_q, last_d;
    logic [W-1:0]   rsp_data_q, rsp_data_d;
    logic           rsp_id_q, rsp_id_d;

    rr_arb2 u_arb (
        .valid0    (bus.req0_valid),
        .valid1    (bus.req1_valid),
        .last      (last_q),
        .grant     (grant),
        .grant_any (grant_any)
    );

    // Operand mux in front of the shared shifter, steered by the grant.
    always_comb begin
        if (grant) begin
            sel_data = bus.req1_data;
            sel_amt  = bus.req1_amt;
            sel_op   = bus.req1_op;
        end else begin
            sel_data = bus.req0_data;
            sel_amt  = bus.req0_amt;
            sel_op   = bus.req0_op;
        end
    end

    funnelShifter u_shift (
        .a  (sel_data),
        .n  (SH_NW'(sel_amt)),
        .op (sel_op),
        .y  (sh_y)
    );

    // A result slot opens when empty or when the held result leaves this cycle.
    assign slot_free = (state_q == EMPTY) || bus.rsp_ready;
    assign accept    = grant_any && slot_free && nrst;

    assign bus.req0_ready = accept && !grant;
    assign bus.req1_ready = accept && grant;

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;

        if (accept) begin
            rsp_data_d = sh_y;
            rsp_id_d   = grant;
            last_d     = grant;
        end

        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (accept) begin
                    state_d = FULL;
                end else if (bus.rsp_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= EMPTY;
            last_q     <= 1'b1;
            rsp_data_q <= '0;
            rsp_id_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
        end
    end

    assign bus.rsp_valid = (state_q == FULL);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter with a cycle-level reference model of arbitration and result stage.
module tb_shift_arbiter;
    import shift_pkg::*;

    logic clk  = 1'b0;
    logic nrst = 1'b1;

    shift_arbiter_if bif ();

    shift_arbiter dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bif)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference shift applied one bit position at a time.
    function automatic logic [7:0] ref_shift(input logic [7:0] d, input int n, input shift_op_t op);
        logic [7:0] r;
        r = d;
        for (int i = 0; i < n; i++) begin
            if (op.rot) r = op.lr ? {r[6:0], r[7]} : {r[0], r[7:1]};
            else if (op.lr) r = r << 1;
            else if (op.ar) r = {r[7], r[7:1]};
            else r = r >> 1;
        end
        return r;
    endfunction

    // Model state: what the output stage must hold and who was granted last.
    logic       m_valid = 1'b0;
    logic [7:0] m_data  = 8'h00;
    logic       m_id    = 1'b0;
    logic       m_last  = 1'b1;
    logic       m_slot;
    logic [1:0] m_rdy;

    assign m_slot = !m_valid || bif.rsp_ready;
    assign m_rdy  = (!nrst || !m_slot) ? 2'b00 :
                    (bif.req0_valid && bif.req1_valid) ? (m_last ? 2'b01 : 2'b10) :
                    {bif.req1_valid, bif.req0_valid};

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_valid <= 1'b0;
            m_data  <= 8'h00;
            m_id    <= 1'b0;
            m_last  <= 1'b1;
        end else if (m_rdy[0]) begin
            m_valid <= 1'b1;
            m_data  <= ref_shift(bif.req0_data, int'(bif.req0_amt), bif.req0_op);
            m_id    <= 1'b0;
            m_last  <= 1'b0;
        end else if (m_rdy[1]) begin
            m_valid <= 1'b1;
            m_data  <= ref_shift(bif.req1_data, int'(bif.req1_amt), bif.req1_op);
            m_id    <= 1'b1;
            m_last  <= 1'b1;
        end else if (bif.rsp_ready) begin
            m_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        check("req0_ready", 32'(bif.req0_ready), 32'(m_rdy[0]));
        check("req1_ready", 32'(bif.req1_ready), 32'(m_rdy[1]));
        check("rsp_valid",  32'(bif.rsp_valid),  32'(m_valid));
        check("rsp_data",   32'(bif.rsp_data),   32'(m_data));
        check("rsp_id",     32'(bif.rsp_id),     32'(m_id));
    end

    logic grants[$];

    task automatic idle();
        bif.req0_valid = 1'b0;
        bif.req1_valid = 1'b0;
    endtask

    task automatic set_req(input bit port, input logic [7:0] d, input logic [2:0] amt, input logic [2:0] op);
        if (port) begin
            bif.req1_data = d; bif.req1_amt = amt; bif.req1_op = shift_op_t'(op); bif.req1_valid = 1'b1;
        end else begin
            bif.req0_data = d; bif.req0_amt = amt; bif.req0_op = shift_op_t'(op); bif.req0_valid = 1'b1;
        end
    endtask

    // Entered and left at posedge+1; checks the literal result one cycle after acceptance.
    task automatic issue(input bit port, input logic [7:0] d, input logic [2:0] amt,
                         input logic [2:0] op, input logic [7:0] exp, input string nm);
        bit ok;
        ok = 1'b0;
        set_req(port, d, amt, op);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (port ? bif.req1_ready : bif.req0_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check({nm, " accepted"}, 32'(ok), 32'd1);
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        check({nm, " valid"}, 32'(bif.rsp_valid), 32'd1);
        check({nm, " data"},  32'(bif.rsp_data),  32'(exp));
        check({nm, " id"},    32'(bif.rsp_id),    32'(port));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bif.rsp_ready = 1'b1;
        bif.req0_data = '0; bif.req0_amt = '0; bif.req0_op = '0; bif.req0_valid = 1'b0;
        bif.req1_data = '0; bif.req1_amt = '0; bif.req1_op = '0; bif.req1_valid = 1'b0;
        #1 nrst = 1'b0;

        // Requests presented during reset must not be accepted.
        set_req(0, 8'h96, 3'd2, 3'b001);
        @(negedge clk);
        check("reset req0_ready", 32'(bif.req0_ready), 32'd0);
        check("reset rsp_valid",  32'(bif.rsp_valid),  32'd0);
        check("reset rsp_data",   32'(bif.rsp_data),   32'h00);
        @(posedge clk); #1;
        idle();
        nrst = 1'b1;
        @(posedge clk); #1;

        issue(0, 8'h96, 3'd2, 3'b001, 8'hE5, "ar_right");
        issue(1, 8'h96, 3'd3, 3'b010, 8'hB0, "lsl");
        issue(0, 8'h96, 3'd4, 3'b100, 8'h69, "rotr");
        issue(1, 8'h81, 3'd1, 3'b110, 8'h03, "rotl");
        issue(0, 8'h96, 3'd2, 3'b000, 8'h25, "lsr");
        issue(1, 8'h76, 3'd3, 3'b001, 8'h0E, "ar_pos");
        issue(0, 8'h96, 3'd7, 3'b110, 8'h4B, "rotl7");
        for (int k = 0; k < 8; k++) issue(k[0], 8'h5A, 3'd0, 3'(k), 8'h5A, "amt0");

        // Fresh reset, then both ports contend continuously.
        nrst = 1'b0;
        @(posedge clk); #1;
        nrst = 1'b1;
        set_req(0, 8'h11, 3'd1, 3'b010);
        set_req(1, 8'h22, 3'd1, 3'b010);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bif.req0_ready) grants.push_back(1'b0);
            if (bif.req1_ready) grants.push_back(1'b1);
            @(posedge clk); #1;
        end
        idle();
        check("alt count", 32'(grants.size()), 32'd6);
        if (grants.size() >= 4) begin
            check("alt g0", 32'(grants[0]), 32'd0);
            check("alt g1", 32'(grants[1]), 32'd1);
            check("alt g2", 32'(grants[2]), 32'd0);
            check("alt g3", 32'(grants[3]), 32'd1);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Backpressure: hold a result for three cycles with a request waiting.
        bif.rsp_ready = 1'b0;
        set_req(0, 8'h96, 3'd2, 3'b001);
        @(negedge clk);
        check("bp first accept", 32'(bif.req0_ready), 32'd1);
        @(posedge clk); #1;
        bif.req0_valid = 1'b0;
        set_req(1, 8'h81, 3'd1, 3'b110);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp req1_ready", 32'(bif.req1_ready), 32'd0);
            check("bp rsp_data",   32'(bif.rsp_data),   32'hE5);
            check("bp rsp_id",     32'(bif.rsp_id),     32'd0);
            @(posedge clk); #1;
        end
        bif.rsp_ready = 1'b1;
        @(negedge clk);
        check("bp release accept", 32'(bif.req1_ready), 32'd1);
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        check("bp second data", 32'(bif.rsp_data), 32'h03);
        check("bp second id",   32'(bif.rsp_id),   32'd1);
        @(posedge clk); #1;

        // Asynchronous reset while FULL with requests pending.
        bif.rsp_ready = 1'b0;
        set_req(0, 8'h96, 3'd2, 3'b001);
        @(negedge clk);
        @(posedge clk); #1;
        set_req(1, 8'h81, 3'd1, 3'b110);
        #2 nrst = 1'b0;
        #1;
        check("arst rsp_valid",  32'(bif.rsp_valid),  32'd0);
        check("arst req0_ready", 32'(bif.req0_ready), 32'd0);
        check("arst req1_ready", 32'(bif.req1_ready), 32'd0);
        @(posedge clk); #1;
        nrst = 1'b1;
        bif.rsp_ready = 1'b1;
        @(negedge clk);
        check("arst tie req0", 32'(bif.req0_ready), 32'd1);
        check("arst tie req1", 32'(bif.req1_ready), 32'd0);
        @(posedge clk); #1;
        idle();
        @(posedge clk); #1;

        // Port 1 streams alone, then port 0 joins and must win the next slot.
        set_req(1, 8'h0F, 3'd0, 3'b000);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("solo req1_ready", 32'(bif.req1_ready), 32'd1);
            @(posedge clk); #1;
        end
        set_req(0, 8'hF0, 3'd1, 3'b000);
        @(negedge clk);
        check("join req0_ready", 32'(bif.req0_ready), 32'd1);
        check("join req1_ready", 32'(bif.req1_ready), 32'd0);
        @(posedge clk); #1;
        bif.req0_valid = 1'b0;
        @(negedge clk);
        check("join next req1", 32'(bif.req1_ready), 32'd1);
        check("join data",      32'(bif.rsp_data),   32'h78);
        @(posedge clk); #1;
        idle();
        @(posedge clk); #1;
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
